// File: rtl/riscv_structures_pkg.sv
// Shared RISC-V pipeline types: decode->execute bundle, ALU ops, execute FSM
// states and the major opcode constants used by execute/writeback.
package riscv_structures;

    typedef enum logic [1:0] {
        ALU_ADD     = 2'd0,
        ALU_EQ      = 2'd1,
        ALU_INVALID = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc_value;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [31:0] immediate_sext;
        alu_op_e     alu_op;
        logic        mem_write;
        logic        reg_write;
        logic        mem_read;
    } de_to_ex_s;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_DONE = 2'd2
    } ex_state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ    = 3'b000;

endpackage

// File: rtl/execute_writeback_if.sv
// Data-memory bus between the execute stage (master) and memory (slave).
interface execute_writeback_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    input  dmem_ack, dmem_rdata);
    modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    output dmem_ack, dmem_rdata);
endinterface

// File: rtl/execute_writeback_alu.sv
// Combinational ALU: 32-bit wrap-around add and equality compare.
module alu
    import riscv_structures::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  alu_op_e     alu_op,
    output logic [31:0] result
);

    // Operation select; unsupported codes yield zero
    always_comb begin
        result = 32'd0;
        case (alu_op)
            ALU_ADD: result = op_a + op_b;
            ALU_EQ:  result = {31'd0, (op_a == op_b)};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/execute_writeback.sv
// Execute/writeback stage: single-cycle ALU/branch/jump results, and a
// three-state handshake with data memory for loads and stores.
module execute_writeback
    import riscv_structures::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  de_to_ex_s                  de_to_ex,
    input  logic                       in_valid,
    output logic                       stall,
    execute_writeback_if.master        dmem,
    output logic [4:0]                 writeback_address,
    output logic [31:0]                write_back_data,
    output logic                       write_back_enable,
    output logic                       redirect_valid,
    output logic [31:0]                redirect_pc,
    output logic                       illegal
);

    ex_state_e   state_r;
    logic        stall_r, dmem_req_r, dmem_we_r, load_wb_r;
    logic [31:0] dmem_addr_r, dmem_wdata_r;
    logic [4:0]  wb_addr_r;
    logic [31:0] wb_data_r, redir_pc_r;
    logic        wb_en_r, redir_valid_r, illegal_r;

    logic        accept_s, is_invalid_s, wb_ok_s, eq_s;
    alu_op_e     main_op_s;
    logic [31:0] alu_res_s, cmp_res_s, pc_imm_s, link_s;
    logic        nxt_wb_en_s, nxt_redir_s, is_mem_s, is_store_s;
    logic [31:0] nxt_wb_data_s, nxt_redir_pc_s;

    // A redirect pulse squashes whatever upstream presents in that cycle
    assign accept_s     = in_valid && !stall_r && !redir_valid_r;
    assign is_invalid_s = (de_to_ex.alu_op == ALU_INVALID);
    assign wb_ok_s      = de_to_ex.reg_write && (de_to_ex.rd != 5'd0);
    assign main_op_s    = (de_to_ex.opcode == OP_R) ? de_to_ex.alu_op : ALU_ADD;
    assign pc_imm_s     = de_to_ex.pc_value + de_to_ex.immediate_sext;
    assign link_s       = de_to_ex.pc_value + 32'd4;
    assign eq_s         = (cmp_res_s != 32'd0);

    alu u_alu_main (
        .op_a   (de_to_ex.rs1_data),
        .op_b   ((de_to_ex.opcode == OP_R) ? de_to_ex.rs2_data : de_to_ex.immediate_sext),
        .alu_op (main_op_s),
        .result (alu_res_s)
    );

    alu u_alu_cmp (
        .op_a   (de_to_ex.rs1_data),
        .op_b   (de_to_ex.rs2_data),
        .alu_op (ALU_EQ),
        .result (cmp_res_s)
    );

    // Decode the presented instruction into its single-cycle effects
    always_comb begin
        nxt_wb_en_s    = 1'b0;
        nxt_wb_data_s  = 32'd0;
        nxt_redir_s    = 1'b0;
        nxt_redir_pc_s = 32'd0;
        is_mem_s       = 1'b0;
        is_store_s     = 1'b0;
        if (is_invalid_s) begin
            nxt_wb_en_s = 1'b0;
        end else begin
            case (de_to_ex.opcode)
                OP_R: begin
                    nxt_wb_en_s   = wb_ok_s;
                    nxt_wb_data_s = alu_res_s;
                end
                OP_LOAD:  is_mem_s = de_to_ex.mem_read;
                OP_STORE: begin
                    is_mem_s   = de_to_ex.mem_write;
                    is_store_s = de_to_ex.mem_write;
                end
                OP_BRANCH: begin
                    if ((de_to_ex.funct3 == F3_BEQ) && eq_s) begin
                        nxt_redir_s    = 1'b1;
                        nxt_redir_pc_s = pc_imm_s;
                    end else begin
                        nxt_redir_s    = 1'b0;
                    end
                end
                OP_JAL: begin
                    nxt_redir_s    = 1'b1;
                    nxt_redir_pc_s = pc_imm_s;
                    nxt_wb_en_s    = wb_ok_s;
                    nxt_wb_data_s  = link_s;
                end
                OP_JALR: begin
                    nxt_redir_s    = 1'b1;
                    nxt_redir_pc_s = {alu_res_s[31:1], 1'b0};
                    nxt_wb_en_s    = wb_ok_s;
                    nxt_wb_data_s  = link_s;
                end
                default: nxt_wb_en_s = 1'b0;
            endcase
        end
    end

    // Stage FSM and all registered outputs; reset discards any pending access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            stall_r       <= 1'b0;
            dmem_req_r    <= 1'b0;
            dmem_we_r     <= 1'b0;
            dmem_addr_r   <= 32'd0;
            dmem_wdata_r  <= 32'd0;
            load_wb_r     <= 1'b0;
            wb_addr_r     <= 5'd0;
            wb_data_r     <= 32'd0;
            wb_en_r       <= 1'b0;
            redir_valid_r <= 1'b0;
            redir_pc_r    <= 32'd0;
            illegal_r     <= 1'b0;
        end else begin
            wb_en_r       <= 1'b0;
            redir_valid_r <= 1'b0;
            illegal_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        illegal_r <= is_invalid_s;
                        wb_addr_r <= de_to_ex.rd;
                        if (is_mem_s) begin
                            state_r      <= MEM_REQ;
                            stall_r      <= 1'b1;
                            dmem_req_r   <= 1'b1;
                            dmem_we_r    <= is_store_s;
                            dmem_addr_r  <= alu_res_s;
                            dmem_wdata_r <= de_to_ex.rs2_data;
                            load_wb_r    <= !is_store_s && wb_ok_s;
                        end else begin
                            wb_en_r       <= nxt_wb_en_s;
                            wb_data_r     <= nxt_wb_data_s;
                            redir_valid_r <= nxt_redir_s;
                            redir_pc_r    <= nxt_redir_pc_s;
                        end
                    end
                end
                MEM_REQ: begin
                    if (dmem.dmem_ack) begin
                        state_r    <= MEM_DONE;
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        wb_en_r    <= load_wb_r;
                        wb_data_r  <= dmem.dmem_rdata;
                    end
                end
                MEM_DONE: begin
                    state_r <= IDLE;
                    stall_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    stall_r    <= 1'b0;
                    dmem_req_r <= 1'b0;
                    dmem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stall             = stall_r;
    assign dmem.dmem_req     = dmem_req_r;
    assign dmem.dmem_we      = dmem_we_r;
    assign dmem.dmem_addr    = dmem_addr_r;
    assign dmem.dmem_wdata   = dmem_wdata_r;
    assign writeback_address = wb_addr_r;
    assign write_back_data   = wb_data_r;
    assign write_back_enable = wb_en_r;
    assign redirect_valid    = redir_valid_r;
    assign redirect_pc       = redir_pc_r;
    assign illegal           = illegal_r;

endmodule

// File: tb/tb_execute_writeback.sv
// Directed and randomized checks of execute_writeback against an
// instruction-level reference model.
module tb_execute_writeback;
    import riscv_structures::*;

    logic        clk = 1'b0;
    logic        rst_n;
    de_to_ex_s   de;
    logic        in_valid;
    logic        stall;
    logic [4:0]  writeback_address;
    logic [31:0] write_back_data;
    logic        write_back_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;

    int vectors     = 0;
    int miscompares = 0;

    execute_writeback_if dmem_if ();

    execute_writeback dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .de_to_ex          (de),
        .in_valid          (in_valid),
        .stall             (stall),
        .dmem              (dmem_if),
        .writeback_address (writeback_address),
        .write_back_data   (write_back_data),
        .write_back_enable (write_back_enable),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .illegal           (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic de_to_ex_s mk(input logic [6:0] opc, input logic [2:0] f3, input alu_op_e op,
                                     input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm, input logic [4:0] rd, input logic rw);
        de_to_ex_s i;
        i.pc_value       = pc;
        i.rs1_data       = rs1;
        i.rs2_data       = rs2;
        i.rd             = rd;
        i.opcode         = opc;
        i.funct3         = f3;
        i.immediate_sext = imm;
        i.alu_op         = op;
        i.reg_write      = rw;
        i.mem_read       = (opc == 7'b0000011);
        i.mem_write      = (opc == 7'b0100011);
        return i;
    endfunction

    // Architectural effect of one instruction, straight from the ISA rules
    function automatic void model(input de_to_ex_s i, input logic [31:0] rdata,
                                  output logic wb, output logic [31:0] wd,
                                  output logic rv, output logic [31:0] rpc, output logic ill,
                                  output logic mem, output logic st, output logic [31:0] addr);
        logic writes;
        ill = (i.alu_op == ALU_INVALID);
        writes = i.reg_write && (i.rd != 5'd0);
        wb = 1'b0; wd = 32'd0; rv = 1'b0; rpc = 32'd0; mem = 1'b0; st = 1'b0;
        addr = i.rs1_data + i.immediate_sext;
        if (!ill) begin
            if (i.opcode == 7'b0110011) begin
                wb = writes; wd = i.rs1_data + i.rs2_data;
            end else if (i.opcode == 7'b0000011) begin
                mem = 1'b1; wb = writes; wd = rdata;
            end else if (i.opcode == 7'b0100011) begin
                mem = 1'b1; st = 1'b1;
            end else if (i.opcode == 7'b1100011) begin
                rv = (i.funct3 == 3'b000) && (i.rs1_data == i.rs2_data);
                rpc = i.pc_value + i.immediate_sext;
            end else if (i.opcode == 7'b1101111) begin
                rv = 1'b1; rpc = i.pc_value + i.immediate_sext;
                wb = writes; wd = i.pc_value + 32'd4;
            end else if (i.opcode == 7'b1100111) begin
                rv = 1'b1; rpc = ((i.rs1_data + i.immediate_sext) >> 1) << 1;
                wb = writes; wd = i.pc_value + 32'd4;
            end
        end
    endfunction

    task automatic issue(input de_to_ex_s i, input string tag);
        logic wb, rv, ill, mem, st;
        logic [31:0] wd, rpc, addr;
        model(i, 32'd0, wb, wd, rv, rpc, ill, mem, st, addr);
        @(negedge clk); de = i; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        chk({tag, "_wbe"}, 32'(write_back_enable), 32'(wb));
        if (wb) begin
            chk({tag, "_wba"}, 32'(writeback_address), 32'(i.rd));
            chk({tag, "_wbd"}, write_back_data, wd);
        end
        chk({tag, "_rv"}, 32'(redirect_valid), 32'(rv));
        if (rv) chk({tag, "_rpc"}, redirect_pc, rpc);
        chk({tag, "_ill"}, 32'(illegal), 32'(ill));
        chk({tag, "_req"}, 32'({dmem_if.dmem_req, stall}), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'({write_back_enable, redirect_valid, illegal}), 32'd0);
    endtask

    // ack is raised in the (delay+1)-th request cycle
    task automatic mem_op(input de_to_ex_s i, input int delay, input logic [31:0] rdata, input string tag);
        logic wb, rv, ill, mem, st;
        logic [31:0] wd, rpc, addr;
        int stall_cnt;
        model(i, rdata, wb, wd, rv, rpc, ill, mem, st, addr);
        stall_cnt = 0;
        @(negedge clk); de = i; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        for (int c = 1; c <= delay + 1; c++) begin
            chk({tag, "_req"}, 32'(dmem_if.dmem_req), 32'd1);
            chk({tag, "_addr"}, dmem_if.dmem_addr, addr);
            chk({tag, "_we"}, 32'(dmem_if.dmem_we), 32'(st));
            if (st) chk({tag, "_wdata"}, dmem_if.dmem_wdata, i.rs2_data);
            chk({tag, "_wbe_wait"}, 32'(write_back_enable), 32'd0);
            stall_cnt += int'(stall);
            if (c == delay + 1) begin
                dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = rdata;
            end
            @(posedge clk); #1;
            dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = $urandom;
        end
        stall_cnt += int'(stall);
        chk({tag, "_req_done"}, 32'(dmem_if.dmem_req), 32'd0);
        chk({tag, "_wbe"}, 32'(write_back_enable), 32'(wb));
        if (wb) begin
            chk({tag, "_wba"}, 32'(writeback_address), 32'(i.rd));
            chk({tag, "_wbd"}, write_back_data, wd);
        end
        @(posedge clk); #1;
        stall_cnt += int'(stall);
        chk({tag, "_wbe_after"}, 32'(write_back_enable), 32'd0);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(delay + 2));
    endtask

    initial begin
        de_to_ex_s i;
        int kind;
        logic [31:0] r1;
        rst_n = 1'b0; in_valid = 1'b0; de = '0;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 32'd0;
        #12;
        chk("reset_ctl", 32'({stall, dmem_if.dmem_req, dmem_if.dmem_we, write_back_enable, redirect_valid, illegal}), 32'd0);
        chk("reset_data", dmem_if.dmem_addr | dmem_if.dmem_wdata | write_back_data | redirect_pc | 32'(writeback_address), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        issue(mk(7'b0110011, 3'd0, ALU_ADD, 32'h0, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1), "add");
        issue(mk(7'b0110011, 3'd0, ALU_ADD, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd9, 1'b1), "add_wrap");
        issue(mk(7'b0110011, 3'd0, ALU_ADD, 32'h0, 32'd5, 32'd7, 32'd0, 5'd0, 1'b1), "add_rd0");
        issue(mk(7'b0110011, 3'd0, ALU_ADD, 32'h0, 32'd5, 32'd7, 32'd0, 5'd4, 1'b0), "add_norw");
        issue(mk(7'b0110011, 3'd0, ALU_INVALID, 32'h0, 32'd5, 32'd7, 32'd0, 5'd4, 1'b1), "invalid");
        issue(mk(7'b1100111, 3'd0, ALU_ADD, 32'h10, 32'h201, 32'd0, 32'd0, 5'd1, 1'b1), "jalr");
        issue(mk(7'b1101111, 3'd0, ALU_ADD, 32'h100, 32'd0, 32'd0, 32'hFFFF_FFF0, 5'd2, 1'b1), "jal");
        issue(mk(7'b1100011, 3'd0, ALU_EQ, 32'h40, 32'd1, 32'd2, 32'hFFFF_FFF8, 5'd0, 1'b0), "beq_nt");
        mem_op(mk(7'b0000011, 3'd2, ALU_ADD, 32'h0, 32'h100, 32'd0, 32'd4, 5'd6, 1'b1), 3, 32'hDEAD_BEEF, "load");
        mem_op(mk(7'b0100011, 3'd2, ALU_ADD, 32'h0, 32'h200, 32'h1234_5678, 32'hFFFF_FFFC, 5'd0, 1'b0), 0, 32'h0, "store");

        // dmem_ack while idle has no effect
        dmem_if.dmem_ack = 1'b1;
        issue(mk(7'b0110011, 3'd0, ALU_ADD, 32'h0, 32'd1, 32'd1, 32'd0, 5'd7, 1'b1), "ack_idle");
        dmem_if.dmem_ack = 1'b0;

        // Taken BEQ; the instruction presented in the redirect cycle is dropped
        @(negedge clk); de = mk(7'b1100011, 3'd0, ALU_EQ, 32'h40, 32'd9, 32'd9, 32'hFFFF_FFF8, 5'd0, 1'b0); in_valid = 1'b1;
        @(posedge clk); #1;
        de = mk(7'b0110011, 3'd0, ALU_ADD, 32'h0, 32'd1, 32'd2, 32'd0, 5'd5, 1'b1);
        chk("beq_rv", 32'(redirect_valid), 32'd1);
        chk("beq_rpc", redirect_pc, 32'h38);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("squash", 32'({write_back_enable, redirect_valid, illegal}), 32'd0);

        // Reset in the middle of a memory request
        @(negedge clk); de = mk(7'b0000011, 3'd2, ALU_ADD, 32'h0, 32'h300, 32'd0, 32'd0, 5'd8, 1'b1); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_req", 32'(dmem_if.dmem_req), 32'd1);
        #2; rst_n = 1'b0; #1;
        chk("rst_req_drop", 32'({dmem_if.dmem_req, stall}), 32'd0);
        @(negedge clk); dmem_if.dmem_ack = 1'b1;
        @(negedge clk); rst_n = 1'b1; dmem_if.dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rst_after", 32'({stall, dmem_if.dmem_req, write_back_enable}), 32'd0);
        @(posedge clk); #1;
        chk("rst_after2", 32'({stall, write_back_enable}), 32'd0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 7);
            r1 = $urandom;
            case (kind)
                0: i = mk(7'b0110011, 3'd0, ALU_ADD, $urandom, r1, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3) != 0);
                1: i = mk(7'b1101111, 3'd0, ALU_ADD, $urandom, r1, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3) != 0);
                2: i = mk(7'b1100111, 3'd0, ALU_ADD, $urandom, r1, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3) != 0);
                3: i = mk(7'b1100011, 3'd0, ALU_EQ, $urandom, r1, ($urandom_range(0, 1) != 0) ? r1 : 32'($urandom), $urandom, 5'd0, 1'b0);
                4: i = mk(7'b0000011, 3'd2, ALU_ADD, $urandom, r1, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3) != 0);
                5: i = mk(7'b0100011, 3'd2, ALU_ADD, $urandom, r1, $urandom, $urandom, 5'($urandom), 1'b0);
                6: i = mk(7'b0000011, 3'd2, ALU_INVALID, $urandom, r1, $urandom, $urandom, 5'($urandom), 1'b1);
                default: i = mk(7'b0010011, 3'd0, ALU_ADD, $urandom, r1, $urandom, $urandom, 5'($urandom), 1'b1);
            endcase
            if ((kind == 4) || (kind == 5))
                mem_op(i, $urandom_range(0, 3), $urandom, "rnd_mem");
            else
                issue(i, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
